// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep controller for a DDS core: steps a registered frequency word
// between two captured bounds in single, sawtooth or triangle fashion.
`timescale 1ns/1ps
module dds_sweep_ctrl #(
    parameter int          FW    = 32,
    parameter int          PW    = 12,
    parameter int          DW    = 24,
    parameter logic [FW-1:0] F_RST = 8589935
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          Start,
    input  logic          Stop,
    input  logic [1:0]    Sweep_Mode,
    input  logic [FW-1:0] F_Start,
    input  logic [FW-1:0] F_Stop,
    input  logic [FW-1:0] F_Step,
    input  logic [DW-1:0] Dwell,
    input  logic [PW-1:0] Pword_In,
    output logic [FW-1:0] Fword,
    output logic [PW-1:0] Pword,
    output logic          Upd,
    output logic          Busy,
    output logic          Done,
    output logic          Cfg_Err
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    state_t        state;
    logic          dir;
    logic [DW-1:0] cnt;

    logic [FW-1:0] f_start_s;
    logic [FW-1:0] f_stop_s;
    logic [FW-1:0] f_step_s;
    logic [DW-1:0] dwell_s;
    logic [1:0]    mode_s;

    logic [FW-1:0] step_f;
    logic          step_dir;
    logic          sweep_end;
    logic          cfg_ok;

    // Sum at FW+1 bits so a carry out of the top is seen and clamped, not wrapped.
    function automatic logic [FW-1:0] sat_add(input logic [FW-1:0] a,
                                              input logic [FW-1:0] b,
                                              input logic [FW-1:0] hi);
        logic [FW:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, hi})
            return hi;
        return s[FW-1:0];
    endfunction

    // A set MSB of the FW+1 bit difference marks a borrow (result below zero).
    function automatic logic [FW-1:0] sat_sub(input logic [FW-1:0] a,
                                              input logic [FW-1:0] b,
                                              input logic [FW-1:0] lo);
        logic [FW:0] d;
        d = {1'b0, a} - {1'b0, b};
        if (d[FW] || (d[FW-1:0] <= lo))
            return lo;
        return d[FW-1:0];
    endfunction

    assign cfg_ok = (F_Step != '0) && (F_Stop >= F_Start);

    always_comb begin
        step_f    = Fword;
        step_dir  = dir;
        sweep_end = 1'b0;
        if (dir == DIR_UP) begin
            if (Fword != f_stop_s) begin
                step_f = sat_add(Fword, f_step_s, f_stop_s);
            end else begin
                case (mode_s)
                    2'd1: step_f = f_start_s;
                    2'd2: begin
                        step_dir = DIR_DOWN;
                        step_f   = sat_sub(f_stop_s, f_step_s, f_start_s);
                    end
                    default: sweep_end = 1'b1;
                endcase
            end
        end else begin
            if (Fword != f_start_s) begin
                step_f = sat_sub(Fword, f_step_s, f_start_s);
            end else begin
                step_dir = DIR_UP;
                step_f   = sat_add(f_start_s, f_step_s, f_stop_s);
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= IDLE;
            dir       <= DIR_UP;
            cnt       <= '0;
            f_start_s <= '0;
            f_stop_s  <= '0;
            f_step_s  <= '0;
            dwell_s   <= '0;
            mode_s    <= '0;
            Fword     <= F_RST;
            Pword     <= '0;
            Upd       <= 1'b0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            Cfg_Err   <= 1'b0;
        end else begin
            Upd     <= 1'b0;
            Done    <= 1'b0;
            Cfg_Err <= 1'b0;
            case (state)
                IDLE: begin
                    // Stop wins over a simultaneous Start, so the pair does nothing here.
                    if (Start && !Stop) begin
                        if (cfg_ok) begin
                            f_start_s <= F_Start;
                            f_stop_s  <= F_Stop;
                            f_step_s  <= F_Step;
                            dwell_s   <= Dwell;
                            mode_s    <= Sweep_Mode;
                            Fword     <= F_Start;
                            Pword     <= Pword_In;
                            cnt       <= '0;
                            dir       <= DIR_UP;
                            Upd       <= 1'b1;
                            Busy      <= 1'b1;
                            state     <= RUN;
                        end else begin
                            Cfg_Err <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (Stop) begin
                        Busy  <= 1'b0;
                        state <= IDLE;
                    end else if (cnt == dwell_s) begin
                        cnt <= '0;
                        if (sweep_end) begin
                            Busy  <= 1'b0;
                            Done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            Fword <= step_f;
                            dir   <= step_dir;
                            Upd   <= (step_f != Fword);
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Scenario bench for dds_sweep_ctrl: expected frequency words are queued per
// scenario and popped as Upd pulses appear.
`timescale 1ns/1ps
module tb_dds_sweep_ctrl;

    localparam int FW = 32;
    localparam int PW = 12;
    localparam int DW = 24;
    localparam logic [FW-1:0] F_RST = 32'd8589935;

    logic          Clk = 1'b0;
    logic          Reset_n = 1'b0;
    logic          Start = 1'b0;
    logic          Stop = 1'b0;
    logic [1:0]    Sweep_Mode = '0;
    logic [FW-1:0] F_Start = '0;
    logic [FW-1:0] F_Stop = '0;
    logic [FW-1:0] F_Step = '0;
    logic [DW-1:0] Dwell = '0;
    logic [PW-1:0] Pword_In = '0;
    logic [FW-1:0] Fword;
    logic [PW-1:0] Pword;
    logic          Upd, Busy, Done, Cfg_Err;

    int checks = 0;
    int errors = 0;
    logic [FW-1:0] exp_q[$];

    dds_sweep_ctrl #(.FW(FW), .PW(PW), .DW(DW), .F_RST(F_RST)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Stop(Stop),
        .Sweep_Mode(Sweep_Mode), .F_Start(F_Start), .F_Stop(F_Stop),
        .F_Step(F_Step), .Dwell(Dwell), .Pword_In(Pword_In),
        .Fword(Fword), .Pword(Pword), .Upd(Upd), .Busy(Busy),
        .Done(Done), .Cfg_Err(Cfg_Err)
    );

    always #5 Clk = ~Clk;

    task automatic set_cfg(input logic [1:0] m, input logic [FW-1:0] fs,
                           input logic [FW-1:0] fe, input logic [FW-1:0] st,
                           input logic [DW-1:0] dw, input logic [PW-1:0] pw);
        Sweep_Mode = m; F_Start = fs; F_Stop = fe; F_Step = st;
        Dwell = dw; Pword_In = pw;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge Clk);
        checks++;
        if (Fword !== F_RST || Pword !== '0) begin
            errors++; $display("FAIL reset_words got %0h/%0h exp %0h/0", Fword, Pword, F_RST);
        end
        checks++;
        if ({Upd, Busy, Done, Cfg_Err} !== 4'b0) begin
            errors++; $display("FAIL reset_flags got %b exp 0000", {Upd, Busy, Done, Cfg_Err});
        end
        Reset_n = 1'b1;
        @(negedge Clk);
        checks++;
        if (Fword !== F_RST || Busy !== 1'b0) begin
            errors++; $display("FAIL reset_release got %0h busy %b exp %0h busy 0", Fword, Busy, F_RST);
        end
    endtask

    task automatic test_reject();
        set_cfg(2'd0, 100, 130, 0, 2, 12'h123);
        Start = 1'b1;
        @(negedge Clk); Start = 1'b0;
        checks++;
        if (Cfg_Err !== 1'b1 || Busy !== 1'b0 || Upd !== 1'b0 || Fword !== F_RST) begin
            errors++; $display("FAIL reject_zero_step got err %b busy %b fword %0h exp 1 0 %0h", Cfg_Err, Busy, Fword, F_RST);
        end
        @(negedge Clk);
        checks++;
        if (Cfg_Err !== 1'b0) begin
            errors++; $display("FAIL reject_pulse_width got %b exp 0", Cfg_Err);
        end
        set_cfg(2'd0, 200, 100, 10, 2, 12'h123);
        Start = 1'b1;
        @(negedge Clk); Start = 1'b0;
        checks++;
        if (Cfg_Err !== 1'b1 || Busy !== 1'b0 || Fword !== F_RST) begin
            errors++; $display("FAIL reject_inverted got err %b busy %b fword %0h exp 1 0 %0h", Cfg_Err, Busy, Fword, F_RST);
        end
        set_cfg(2'd0, 100, 130, 10, 2, 12'h123);
        Start = 1'b1; Stop = 1'b1;
        @(negedge Clk); Start = 1'b0; Stop = 1'b0;
        checks++;
        if (Upd !== 1'b0 || Busy !== 1'b0 || Cfg_Err !== 1'b0 || Fword !== F_RST || Pword !== '0) begin
            errors++; $display("FAIL start_stop_idle got upd %b busy %b err %b fword %0h exp 0 0 0 %0h", Upd, Busy, Cfg_Err, Fword, F_RST);
        end
    endtask

    task automatic test_single_sweep();
        logic [FW-1:0] e;
        int upd_n = 0;
        set_cfg(2'd0, 100, 130, 10, 2, 12'h5A5);
        exp_q = {32'd100, 32'd110, 32'd120, 32'd130};
        Start = 1'b1;
        for (int k = 0; k < 15; k++) begin
            @(negedge Clk); Start = 1'b0;
            checks++;
            if (Upd !== ((k % 3 == 0) && k <= 9)) begin
                errors++; $display("FAIL single_upd_time k=%0d got %b", k, Upd);
            end
            if (Upd === 1'b1) begin
                upd_n++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL single_fword k=%0d got %0d exp none", k, Fword);
                end else begin
                    e = exp_q.pop_front();
                    if (Fword !== e) begin
                        errors++; $display("FAIL single_fword k=%0d got %0d exp %0d", k, Fword, e);
                    end
                end
            end
            checks++;
            if (Done !== (k == 12) || Busy !== (k < 12)) begin
                errors++; $display("FAIL single_done_busy k=%0d got %b%b exp %b%b", k, Done, Busy, k == 12, k < 12);
            end
        end
        checks++;
        if (upd_n != 4 || Fword !== 130 || Pword !== 12'h5A5) begin
            errors++; $display("FAIL single_totals got upd %0d fword %0d pword %0h exp 4 130 5a5", upd_n, Fword, Pword);
        end
    endtask

    task automatic test_clamp();
        logic [FW-1:0] e;
        set_cfg(2'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h10, 0, 12'h001);
        exp_q = {32'hFFFF_FFF0, 32'hFFFF_FFFF};
        Start = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge Clk); Start = 1'b0;
            checks++;
            if (Upd !== (k <= 1) || Done !== (k == 2) || Fword < 32'hFFFF_FFF0) begin
                errors++; $display("FAIL clamp_step k=%0d got upd %b done %b fword %0h", k, Upd, Done, Fword);
            end
            if (Upd === 1'b1 && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++;
                if (Fword !== e) begin
                    errors++; $display("FAIL clamp_fword k=%0d got %0h exp %0h", k, Fword, e);
                end
            end
        end
        checks++;
        if (exp_q.size() != 0 || Busy !== 1'b0) begin
            errors++; $display("FAIL clamp_end got left %0d busy %b exp 0 0", exp_q.size(), Busy);
        end
    endtask

    task automatic test_triangle();
        logic [FW-1:0] e;
        set_cfg(2'd2, 100, 120, 10, 0, 12'h002);
        exp_q = {32'd100, 32'd110, 32'd120, 32'd110, 32'd100,
                 32'd110, 32'd120, 32'd110, 32'd100, 32'd110};
        Start = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge Clk); Start = 1'b0;
            e = exp_q.pop_front();
            checks++;
            if (Upd !== 1'b1 || Done !== 1'b0 || Fword !== e) begin
                errors++; $display("FAIL triangle k=%0d got upd %b done %b fword %0d exp 1 0 %0d", k, Upd, Done, Fword, e);
            end
        end
        Stop = 1'b1;
        @(negedge Clk); Stop = 1'b0;
        checks++;
        if (Busy !== 1'b0 || Upd !== 1'b0 || Done !== 1'b0 || Fword !== 110) begin
            errors++; $display("FAIL triangle_stop got busy %b upd %b done %b fword %0d exp 0 0 0 110", Busy, Upd, Done, Fword);
        end
    endtask

    task automatic test_sawtooth();
        logic [FW-1:0] e;
        set_cfg(2'd1, 100, 120, 10, 1, 12'h003);
        exp_q = {32'd100, 32'd110, 32'd120, 32'd100, 32'd110};
        Start = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge Clk); Start = 1'b0;
            if (k == 0) begin
                F_Start = 7; F_Stop = 9999; F_Step = 1; Sweep_Mode = 2'd0;
            end
            if (k == 4) Start = 1'b1;
            checks++;
            if (Upd !== (k % 2 == 0) || Done !== 1'b0 || Busy !== 1'b1) begin
                errors++; $display("FAIL sawtooth_flags k=%0d got upd %b done %b busy %b", k, Upd, Done, Busy);
            end
            if (Upd === 1'b1 && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++;
                if (Fword !== e) begin
                    errors++; $display("FAIL sawtooth_fword k=%0d got %0d exp %0d", k, Fword, e);
                end
            end
        end
        Start = 1'b0; Stop = 1'b1;
        @(negedge Clk); Stop = 1'b0;
        checks++;
        if (Busy !== 1'b0) begin
            errors++; $display("FAIL sawtooth_stop got busy %b exp 0", Busy);
        end
    endtask

    task automatic test_equal_bounds();
        set_cfg(2'd2, 500, 500, 7, 1, 12'h004);
        Start = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge Clk); Start = 1'b0;
            checks++;
            if (Upd !== (k == 0) || Fword !== 500 || Busy !== 1'b1 || Done !== 1'b0) begin
                errors++; $display("FAIL equal_tri k=%0d got upd %b fword %0d busy %b exp %b 500 1", k, Upd, Fword, Busy, k == 0);
            end
        end
        Stop = 1'b1;
        @(negedge Clk); Stop = 1'b0;
        set_cfg(2'd3, 500, 500, 7, 1, 12'h004);
        Start = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge Clk); Start = 1'b0;
            checks++;
            if (Done !== (k == 2) || Busy !== (k < 2) || Fword !== 500) begin
                errors++; $display("FAIL equal_single k=%0d got done %b busy %b fword %0d", k, Done, Busy, Fword);
            end
        end
    endtask

    task automatic test_abort();
        logic [FW-1:0] e;
        set_cfg(2'd0, 100, 130, 10, 2, 12'h006);
        exp_q = {32'd100, 32'd110};
        Start = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge Clk); Start = 1'b0;
            if (Upd === 1'b1) begin
                checks++;
                e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
                if (Fword !== e) begin
                    errors++; $display("FAIL abort_fword k=%0d got %0d exp %0d", k, Fword, e);
                end
            end
        end
        Stop = 1'b1;
        @(negedge Clk); Stop = 1'b0;
        checks++;
        if (Busy !== 1'b0 || Fword !== 110 || Done !== 1'b0 || Upd !== 1'b0 || exp_q.size() != 0) begin
            errors++; $display("FAIL abort_stop got busy %b fword %0d done %b upd %b exp 0 110 0 0", Busy, Fword, Done, Upd);
        end
        repeat (6) @(negedge Clk);
        checks++;
        if (Fword !== 110 || Done !== 1'b0 || Busy !== 1'b0) begin
            errors++; $display("FAIL abort_hold got fword %0d done %b busy %b exp 110 0 0", Fword, Done, Busy);
        end
        Start = 1'b1;
        @(negedge Clk); Start = 1'b0;
        checks++;
        if (Upd !== 1'b1 || Fword !== 100 || Busy !== 1'b1) begin
            errors++; $display("FAIL abort_restart got upd %b fword %0d busy %b exp 1 100 1", Upd, Fword, Busy);
        end
        Stop = 1'b1;
        @(negedge Clk); Stop = 1'b0;
    endtask

    task automatic test_reset_mid();
        set_cfg(2'd1, 1000, 2000, 100, 0, 12'h7FF);
        Start = 1'b1;
        repeat (3) begin
            @(negedge Clk); Start = 1'b0;
        end
        checks++;
        if (Busy !== 1'b1 || Fword !== 1200) begin
            errors++; $display("FAIL midreset_pre got busy %b fword %0d exp 1 1200", Busy, Fword);
        end
        Reset_n = 1'b0;
        #1;
        checks++;
        if (Fword !== F_RST || Busy !== 1'b0 || Pword !== '0 || Upd !== 1'b0) begin
            errors++; $display("FAIL midreset_async got fword %0d busy %b pword %0h exp %0d 0 0", Fword, Busy, Pword, F_RST);
        end
        @(negedge Clk); Reset_n = 1'b1;
        repeat (2) @(negedge Clk);
        checks++;
        if (Fword !== F_RST || Busy !== 1'b0 || Upd !== 1'b0) begin
            errors++; $display("FAIL midreset_after got fword %0d busy %b exp %0d 0", Fword, Busy, F_RST);
        end
    endtask

    initial begin
        test_reset();
        test_reject();
        test_single_sweep();
        test_clamp();
        test_triangle();
        test_sawtooth();
        test_equal_bounds();
        test_abort();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dds_sweep_ctrl.md
DDS_SWEEP_CTRL -- requirements
Module: dds_sweep_ctrl

Interface
REQ-001 SHALL have parameter FW, default 32, Fword width.
REQ-002 SHALL have parameter PW, default 12, Pword width.
REQ-003 SHALL have parameter DW, default 24, dwell counter width.
REQ-004 SHALL have parameter F_RST, default 8589935, Fword reset value.
REQ-005 SHALL have port Clk  input  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port Reset_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port Start  input  1  one-cycle sweep-start pulse.
REQ-008 SHALL have port Stop  input  1  one-cycle abort pulse.
REQ-009 SHALL have port Sweep_Mode  input  2  0 = single up, 1 = repeat sawtooth, 2 = triangle, 3 = same as 0.
REQ-010 SHALL have port F_Start  input  FW  lower sweep bound.
REQ-011 SHALL have port F_Stop  input  FW  upper sweep bound.
REQ-012 SHALL have port F_Step  input  FW  step increment.
REQ-013 SHALL have port Dwell  input  DW  each frequency is held Dwell+1 cycles.
REQ-014 SHALL have port Pword_In  input  PW  phase word for the sweep.
REQ-015 SHALL have port Fword  output  FW  registered frequency word to the DDS.
REQ-016 SHALL have port Pword  output  PW  registered phase word to the DDS.
REQ-017 SHALL have port Upd  output  1  one-cycle pulse in the cycle Fword takes a new value.
REQ-018 SHALL have port Busy  output  1  high while sweeping.
REQ-019 SHALL have port Done  output  1  one-cycle pulse at single-sweep completion.
REQ-020 SHALL have port Cfg_Err  output  1  one-cycle pulse on a rejected Start.

Function
REQ-021 SHALL implement the states IDLE and RUN, plus a direction bit (up/down) and a dwell counter cnt.
REQ-022 SHALL, in IDLE on Start with valid configuration (F_Step != 0 and F_Stop >= F_Start), capture all configuration inputs into shadow registers, set Fword = F_Start, Pword = Pword_In, cnt = 0, dir = up, pulse Upd, set Busy = 1, and enter RUN.
REQ-023 SHALL, on Start with invalid configuration, pulse Cfg_Err and leave the state, Fword and Pword unchanged.
REQ-024 SHALL ignore configuration input changes after capture; Start is ignored in RUN.
REQ-025 SHALL, in RUN, increment cnt each cycle; when cnt == Dwell_s, set cnt = 0 and perform the step rule below.
REQ-026 SHALL apply this step rule when dir is up and Fword != F_Stop: Fword = min(Fword + F_Step, F_Stop).
REQ-027 SHALL apply this step rule when dir is up and Fword == F_Stop: mode 0/3 enters IDLE with Busy = 0 and a Done pulse, Fword held; mode 1 sets Fword = F_Start; mode 2 sets dir = down and Fword = max(F_Stop - F_Step, F_Start).
REQ-028 SHALL apply this step rule when dir is down and Fword != F_Start: Fword = max(Fword - F_Step, F_Start).
REQ-029 SHALL apply this step rule when dir is down and Fword == F_Start: dir = up and Fword = min(F_Start + F_Step, F_Stop).
REQ-030 SHALL compute sums and differences at FW+1 bits so that no overflow or underflow wrap occurs; results clamp to the bounds.
REQ-031 SHALL pulse Upd only when the registered Fword value actually changes, or on Start.
REQ-032 SHALL, on Stop in RUN, enter IDLE on the next edge with Busy = 0, Fword and Pword held, and no Done or Upd pulse.
REQ-033 SHALL give Stop priority when Start and Stop are asserted in the same cycle; Stop in IDLE has no effect.
REQ-034 SHALL, with F_Start == F_Stop, hold F_Start for Dwell+1 cycles and then treat it as the top of the sweep; in mode 1 and mode 2 the output stays at F_Start with no Upd pulses.
REQ-035 SHALL drive all outputs directly from registers.

Reset
REQ-036 SHALL, on Reset_n = 0, immediately set the state to IDLE, Fword = F_RST, Pword = 0, Upd = Busy = Done = Cfg_Err = 0, cnt = 0, dir = up, and clear the shadow registers, including during RUN.
REQ-037 SHALL take no action on any input until the first edge after Reset_n is released.

Verification
REQ-038 SHALL cover single sweep: F_Start = 100, F_Stop = 130, F_Step = 10, Dwell = 2, mode 0, Start at edge 0 -> Fword 100 after edge 0, 110 after edge 3, 120 after edge 6, 130 after edge 9; Done pulse and Busy = 0 after edge 12; 4 Upd pulses total.
REQ-039 SHALL cover clamp and overflow: F_Start = 0xFFFFFFF0, F_Stop = 0xFFFFFFFF, F_Step = 0x10, Dwell = 0, mode 0 -> Fword sequence 0xFFFFFFF0, 0xFFFFFFFF, then Done; no wrap to a low value.
REQ-040 SHALL cover triangle: 100/120/step 10, Dwell = 0, mode 2 -> 100, 110, 120, 110, 100, 110, 120 on consecutive cycles; no Done.
REQ-041 SHALL cover abort: Stop in the cycle Fword = 110 of the REQ-038 setup -> Busy = 0 next edge, Fword stays 110, no Done, and a subsequent Start restarts at 100.
REQ-042 SHALL cover rejection and priority: Start with F_Step = 0 -> Cfg_Err pulse, Busy stays 0, Fword stays F_RST; Start and Stop asserted together in IDLE -> no action.
REQ-043 SHALL cover reset mid-sweep: Reset_n low during RUN -> Fword = 8589935 and Busy = 0 without waiting for a clock edge.
